// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its matching detector:
// state encoding, default pattern width and the derived length-field width.
package seq_pkg;

   localparam int MAX_LEN_DEF = 8;
   localparam int REP_W_DEF   = 8;
   localparam int GAP_W_DEF   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Width needed to hold a length of 0..max_len inclusive.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/stream bundle between a pattern-generator controller (master) and the generator (slave).
interface seq_pattern_gen_if #(
   parameter int MAX_LEN = seq_pkg::MAX_LEN_DEF,
   parameter int REP_W   = seq_pkg::REP_W_DEF,
   parameter int GAP_W   = seq_pkg::GAP_W_DEF
);
   import seq_pkg::*;

   localparam int LEN_W = len_w(MAX_LEN);

   // load/start are single-cycle requests honoured only while busy is low; abort is honoured
   // in any state. x is meaningful only when valid is high; the stream has no back-pressure.
   logic               load;
   logic               start;
   logic               abort;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   len;
   logic [REP_W-1:0]   reps;
   logic [GAP_W-1:0]   gap;
   logic               x;
   logic               valid;
   logic               busy;
   logic               done;
   state_t             state;

   modport master (
      output load, start, abort, pattern, len, reps, gap,
      input  x, valid, busy, done, state
   );

   modport slave (
      input  load, start, abort, pattern, len, reps, gap,
      output x, valid, busy, done, state
   );

endinterface

// File: rtl/seq_piso.sv
// Parallel-load shift stage: holds the pattern and walks a bit index down from len-1 to 0.
module seq_piso #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld,
   input  logic [MAX_LEN-1:0] din,
   input  logic [LEN_W-1:0]   len,
   input  logic               shift,
   output logic               bit_out,
   output logic               last
);

   logic [MAX_LEN-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (ld) begin
         shreg_d = din;
         cnt_d   = (len == '0) ? '0 : CNT_W'(len - LEN_W'(1));
      end else if (shift && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bit_out = shreg_q[cnt_q];
   assign last    = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern generator: shifts a programmed pattern out MSB-first, repeated a
// programmed number of times with optional idle gaps between repetitions.
module seq_pattern_gen
   import seq_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int REP_W   = REP_W_DEF,
   parameter int GAP_W   = GAP_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   seq_pattern_gen_if.slave bus
);

   localparam int LEN_W = len_w(MAX_LEN);
   localparam int CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [REP_W-1:0]   reps_q, reps_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

   logic               piso_ld, piso_shift, piso_bit, piso_last;
   logic [MAX_LEN-1:0] piso_din;
   logic [LEN_W-1:0]   piso_len;

   logic [LEN_W-1:0]   len_clamp;
   logic [MAX_LEN-1:0] pat_eff;
   logic [LEN_W-1:0]   len_eff;
   logic [REP_W-1:0]   reps_eff;

   // A start coinciding with load must see the freshly presented values, not the old shadow.
   assign len_clamp = (bus.len > MAX_LEN_V) ? MAX_LEN_V : bus.len;
   assign pat_eff   = bus.load ? bus.pattern : pat_q;
   assign len_eff   = bus.load ? len_clamp   : len_q;
   assign reps_eff  = bus.load ? bus.reps    : reps_q;

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      len_d      = len_q;
      reps_d     = reps_q;
      gap_d      = gap_q;
      rep_cnt_d  = rep_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      piso_ld    = 1'b0;
      piso_shift = 1'b0;
      piso_din   = pat_q;
      piso_len   = len_q;
      if (bus.abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.load) begin
                  pat_d  = bus.pattern;
                  len_d  = len_clamp;
                  reps_d = bus.reps;
                  gap_d  = bus.gap;
               end
               if (bus.start) begin
                  if (len_eff == '0 || reps_eff == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d   = ST_SHIFT;
                     piso_ld   = 1'b1;
                     piso_din  = pat_eff;
                     piso_len  = len_eff;
                     rep_cnt_d = reps_eff;
                  end
               end
            end
            ST_SHIFT: begin
               if (!piso_last) begin
                  piso_shift = 1'b1;
               end else if (rep_cnt_q > REP_W'(1)) begin
                  rep_cnt_d = rep_cnt_q - REP_W'(1);
                  if (gap_q != '0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = gap_q;
                  end else begin
                     piso_ld = 1'b1;
                  end
               end else begin
                  state_d   = ST_DONE;
                  rep_cnt_d = '0;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q <= GAP_W'(1)) begin
                  gap_cnt_d = '0;
                  state_d   = ST_SHIFT;
                  piso_ld   = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         reps_q    <= '0;
         gap_q     <= '0;
         rep_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         reps_q    <= reps_d;
         gap_q     <= gap_d;
         rep_cnt_q <= rep_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   seq_piso #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) u_piso (
      .clk     (clk),
      .rst     (rst),
      .ld      (piso_ld),
      .din     (piso_din),
      .len     (piso_len),
      .shift   (piso_shift),
      .bit_out (piso_bit),
      .last    (piso_last)
   );

   // Outputs decode flops only, so an async reset clears them immediately.
   assign bus.x     = (state_q == ST_SHIFT) && piso_bit;
   assign bus.valid = (state_q == ST_SHIFT);
   assign bus.busy  = (state_q != ST_IDLE);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.state = state_q;

endmodule
